// File: rtl/kan_pkg.sv
// Shared constants, FSM state encoding and data word type for the KAN error accumulator.
// No logic; imported by the accumulator top and its pipeline stage.
package kan_pkg;

    localparam int DATA_W       = 32;
    localparam int DIFF_W       = DATA_W + 1;
    localparam int N_BASE_SHIFT = 11;
    localparam int ACC_W_DEF    = 48;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ACCUM = 3'd1,
        DRAIN = 3'd2,
        FINAL = 3'd3,
        DONE  = 3'd4
    } acc_state_t;

    typedef logic signed [DATA_W-1:0] kan_word_t;

endpackage

// File: rtl/kan_abs_diff.sv
// Pipeline stage 1: registered 33-bit |target - pred| with valid passthrough.
// One cycle latency, one pair per cycle; no backpressure (always accepts).
module kan_abs_diff
    import kan_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              vld_i,
    input  logic [31:0]       pred_i,
    input  logic [31:0]       target_i,
    output logic              vld_o,
    output logic [DIFF_W-1:0] abs_o
);

    logic signed [DIFF_W-1:0] diff;
    logic        [DIFF_W-1:0] abs_d;
    logic        [DIFF_W-1:0] abs_q;
    logic                     vld_q;

    // Sign-extending to 33 bits keeps the worst case -(2^32-1) representable.
    always_comb begin
        diff  = $signed({target_i[31], target_i}) - $signed({pred_i[31], pred_i});
        abs_d = diff[DIFF_W-1] ? DIFF_W'(-diff) : DIFF_W'(diff);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vld_q <= 1'b0;
            abs_q <= '0;
        end else begin
            vld_q <= vld_i;
            if (vld_i) begin
                abs_q <= abs_d;
            end
        end
    end

    assign vld_o = vld_q;
    assign abs_o = abs_q;

endmodule

// File: rtl/kan_error_accumulator.sv
// Mean absolute error over one pass (sum >> N_REC_SHIFT); err_valid at t_last+4, one pair/cycle in ACCUM.
// in_ready only in ACCUM; KAN_LED_CYCLES_EN shows a pass cycle count on LED instead of the error.
module kan_error_accumulator
    import kan_pkg::*;
#(
    parameter int N_RECORDS   = 2048,
    parameter int N_REC_SHIFT = N_BASE_SHIFT,
    parameter int ACC_W       = ACC_W_DEF
) (
    input  logic        CLK100MHZ,
    input  logic        CPU_RESETN,
    input  logic        start,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_pred,
    input  logic [31:0] in_target,
    input  logic        in_last,
    output logic        busy,
    output logic        err_valid,
    output logic [31:0] err_value,
    output logic        cnt_err,
    output logic [15:0] LED
);

    localparam logic [ACC_W-1:0] ACC_MAX  = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] MEAN_MAX = ACC_W'(32'h7FFF_FFFF);

    acc_state_t        state_q, state_d;
    logic              drain_q, drain_d;
    logic [ACC_W-1:0]  acc_q;
    logic [31:0]       rec_cnt_q;
    kan_word_t         err_value_q;
    logic              err_valid_q;
    logic              cnt_err_q;

    logic              accept;
    logic              start_acc;
    logic              abs_vld;
    logic [DIFF_W-1:0] abs_val;
    logic [ACC_W:0]    sum;
    logic [ACC_W-1:0]  mean;

    assign in_ready  = (state_q == ACCUM);
    assign accept    = in_valid && in_ready;
    assign start_acc = start && ((state_q == IDLE) || (state_q == DONE));
    assign busy      = (state_q == ACCUM) || (state_q == DRAIN) || (state_q == FINAL);

    kan_abs_diff u_abs_diff (
        .clk_i    (CLK100MHZ),
        .rst_ni   (CPU_RESETN),
        .vld_i    (accept),
        .pred_i   (in_pred),
        .target_i (in_target),
        .vld_o    (abs_vld),
        .abs_o    (abs_val)
    );

    always_comb begin
        state_d = state_q;
        drain_d = drain_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = ACCUM;
                end
            end
            ACCUM: begin
                if (accept && in_last) begin
                    state_d = DRAIN;
                    drain_d = 1'b0;
                end
            end
            // Two drain cycles let the last pair pass the abs stage and land in acc.
            DRAIN: begin
                if (drain_q) begin
                    state_d = FINAL;
                end else begin
                    drain_d = 1'b1;
                end
            end
            FINAL:   state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            state_q <= IDLE;
            drain_q <= 1'b0;
        end else begin
            state_q <= state_d;
            drain_q <= drain_d;
        end
    end

    always_comb begin
        sum  = {1'b0, acc_q} + (ACC_W+1)'(abs_val);
        mean = acc_q >> N_REC_SHIFT;
    end

    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            acc_q     <= '0;
            rec_cnt_q <= '0;
        end else if (start_acc) begin
            acc_q     <= '0;
            rec_cnt_q <= '0;
        end else begin
            if (abs_vld) begin
                acc_q <= (sum > {1'b0, ACC_MAX}) ? ACC_MAX : sum[ACC_W-1:0];
            end
            if (accept) begin
                rec_cnt_q <= rec_cnt_q + 32'd1;
            end
        end
    end

    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            err_value_q <= '0;
            err_valid_q <= 1'b0;
            cnt_err_q   <= 1'b0;
        end else if (start_acc) begin
            err_value_q <= '0;
            err_valid_q <= 1'b0;
            cnt_err_q   <= 1'b0;
        end else begin
            err_valid_q <= (state_q == FINAL);
            if (state_q == FINAL) begin
                err_value_q <= (mean > MEAN_MAX) ? 32'sh7FFF_FFFF : kan_word_t'(mean[31:0]);
                cnt_err_q   <= (rec_cnt_q != 32'(N_RECORDS));
            end
        end
    end

    assign err_value = err_value_q;
    assign err_valid = err_valid_q;
    assign cnt_err   = cnt_err_q;

`ifdef KAN_LED_CYCLES_EN
    logic [31:0] cycle_count_q;

    // Counts every cycle from the accepted start through the err_valid cycle inclusive.
    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            cycle_count_q <= '0;
        end else if (start_acc) begin
            cycle_count_q <= 32'd1;
        end else if ((busy || err_valid_q) && (cycle_count_q != 32'hFFFF_FFFF)) begin
            cycle_count_q <= cycle_count_q + 32'd1;
        end
    end

    assign LED = cycle_count_q[31:16];
`else
    always_comb begin
        LED = err_value_q[15:0];
        if (err_value_q[31]) begin
            LED = 16'h0000;
        end else if (err_value_q > 32'sh0000_FFFF) begin
            LED = 16'hFFFF;
        end
    end
`endif

endmodule

// File: tb/tb_kan_error_accumulator.sv
// Directed bench for kan_error_accumulator: per-scenario tasks with hand-computed expectations.
module tb_kan_error_accumulator;

    logic        CLK100MHZ = 1'b0;
    logic        CPU_RESETN = 1'b0;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_pred = '0;
    logic [31:0] in_target = '0;
    logic        in_last = 1'b0;
    logic        busy;
    logic        err_valid;
    logic [31:0] err_value;
    logic        cnt_err;
    logic [15:0] LED;

    int tests_run = 0;
    int tests_failed = 0;
    int cyc = 0;
    int ev_cnt = 0;

    kan_error_accumulator dut (
        .CLK100MHZ  (CLK100MHZ),
        .CPU_RESETN (CPU_RESETN),
        .start      (start),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_pred    (in_pred),
        .in_target  (in_target),
        .in_last    (in_last),
        .busy       (busy),
        .err_valid  (err_valid),
        .err_value  (err_value),
        .cnt_err    (cnt_err),
        .LED        (LED)
    );

    always #5 CLK100MHZ = ~CLK100MHZ;

    always @(posedge CLK100MHZ) cyc <= cyc + 1;
    always @(negedge CLK100MHZ) if (err_valid === 1'b1) ev_cnt <= ev_cnt + 1;

    function automatic logic [31:0] f_pred(input int kind, input int i);
        case (kind)
            1:       return 32'd100;
            2:       return (i == 0) ? 32'h7FFF_FFFF : 32'd0;
            3:       return -32'sd1000;
            4:       return 32'd7;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] f_tgt(input int kind, input int i);
        case (kind)
            0:       return 32'd1000;
            1:       return (i % 2 == 0) ? 32'd3100 : -32'sd2900;
            2:       return (i == 0) ? 32'h8000_0000 : 32'd0;
            3:       return 32'd1048;
            4:       return 32'd12;
            default: return 32'(i);
        endcase
    endfunction

    // Stimulus only: one pass, returns observed timing/flags for the caller to judge.
    task automatic run_pass(input int n, input int kind, input bit gap, input bit hold, input int mid,
                            output int t_first, output int t_last, output int t_ev,
                            output bit rdy_after, output bit clr_seen, output bit busy_ev);
        int idx;
        int k;
        t_first = -1; t_last = -1; t_ev = -1; busy_ev = 1'b1;
        @(negedge CLK100MHZ);
        start = 1'b1; in_valid = hold; in_last = 1'b0;
        in_pred = f_pred(kind, 0); in_target = f_tgt(kind, 0);
        @(negedge CLK100MHZ);
        start = 1'b0;
        clr_seen = (err_value === 32'd0) && (cnt_err === 1'b0) && (busy === 1'b1) && (in_ready === 1'b1);
        idx = 0; k = 0;
        while (idx < n && k < 2 * n + 50) begin
            in_valid  = !(gap && (k % 3 == 2));
            in_pred   = f_pred(kind, idx);
            in_target = f_tgt(kind, idx);
            in_last   = (idx == n - 1);
            start     = (idx == mid);
            if (in_valid && in_ready) begin
                if (idx == 0) t_first = cyc;
                if (idx == n - 1) t_last = cyc;
                idx++;
            end
            k++;
            @(negedge CLK100MHZ);
        end
        start = 1'b0; in_valid = hold; in_last = 1'b0;
        rdy_after = in_ready;
        for (int w = 0; w < 20; w++) begin
            if (err_valid === 1'b1) begin
                t_ev = cyc; busy_ev = busy;
                break;
            end
            @(negedge CLK100MHZ);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge CLK100MHZ);
        tests_run++;
        if ({busy, err_valid, cnt_err, in_ready} !== 4'b0000) begin
            tests_failed++;
            $display("FAIL reset_flags: busy/err_valid/cnt_err/in_ready=%b required 0000",
                     {busy, err_valid, cnt_err, in_ready});
        end
        tests_run++;
        if (err_value !== 32'd0 || LED !== 16'd0) begin
            tests_failed++;
            $display("FAIL reset_values: err_value=%0d LED=%h required 0/0000", err_value, LED);
        end
        CPU_RESETN = 1'b1;
        repeat (2) @(negedge CLK100MHZ);
    endtask

    task automatic test_mean_basic();
        int tf, tl, te; bit ra, cs, be;
        run_pass(2048, 0, 1'b1, 1'b0, -1, tf, tl, te, ra, cs, be);
        tests_run++;
        if (!cs) begin tests_failed++; $display("FAIL basic_start_clear: observed 0 required 1"); end
        tests_run++;
        if (te !== tl + 4) begin tests_failed++; $display("FAIL basic_latency: err_valid at %0d required %0d", te, tl + 4); end
        tests_run++;
        if (ra !== 1'b0) begin tests_failed++; $display("FAIL basic_ready_drop: in_ready=%b required 0", ra); end
        tests_run++;
        if (err_value !== 32'd1000 || cnt_err !== 1'b0 || LED !== 16'h03E8 || be !== 1'b0) begin
            tests_failed++;
            $display("FAIL basic_result: err=%0d cnt_err=%b LED=%h busy=%b required 1000/0/03e8/0",
                     err_value, cnt_err, LED, be);
        end
        @(negedge CLK100MHZ);
        tests_run++;
        if (err_valid !== 1'b0 || err_value !== 32'd1000) begin
            tests_failed++;
            $display("FAIL basic_pulse_hold: err_valid=%b err=%0d required 0/1000", err_valid, err_value);
        end
    endtask

    task automatic test_alternating();
        int tf, tl, te; bit ra, cs, be;
        run_pass(2048, 1, 1'b0, 1'b0, -1, tf, tl, te, ra, cs, be);
        tests_run++;
        if (err_value !== 32'd3000 || LED !== 16'h0BB8 || cnt_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL alt_result: err=%0d LED=%h cnt_err=%b required 3000/0bb8/0", err_value, LED, cnt_err);
        end
    endtask

    task automatic test_short_pass();
        int tf, tl, te; bit ra, cs, be;
        run_pass(2047, 3, 1'b0, 1'b0, -1, tf, tl, te, ra, cs, be);
        tests_run++;
        if (err_value !== 32'd2047 || cnt_err !== 1'b1 || LED !== 16'h07FF) begin
            tests_failed++;
            $display("FAIL short_result: err=%0d cnt_err=%b LED=%h required 2047/1/07ff", err_value, cnt_err, LED);
        end
        tests_run++;
        if (te !== tl + 4) begin tests_failed++; $display("FAIL short_latency: err_valid at %0d required %0d", te, tl + 4); end
    endtask

    task automatic test_extreme();
        int tf, tl, te; bit ra, cs, be;
        run_pass(2048, 2, 1'b0, 1'b0, -1, tf, tl, te, ra, cs, be);
        tests_run++;
        if (!cs) begin tests_failed++; $display("FAIL extreme_clear_cnt_err: observed 0 required 1"); end
        tests_run++;
        if (err_value !== 32'd2097151 || LED !== 16'hFFFF || cnt_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL extreme_result: err=%0d LED=%h cnt_err=%b required 2097151/ffff/0", err_value, LED, cnt_err);
        end
    endtask

    task automatic test_reset_abort();
        int tf, tl, te; bit ra, cs, be;
        int ev0;
        @(negedge CLK100MHZ);
        start = 1'b1;
        @(negedge CLK100MHZ);
        start = 1'b0;
        in_valid = 1'b1; in_pred = 32'd0; in_target = 32'd999;
        repeat (1000) @(negedge CLK100MHZ);
        ev0 = ev_cnt;
        CPU_RESETN = 1'b0;
        #1;
        tests_run++;
        if (busy !== 1'b0 || in_ready !== 1'b0 || err_value !== 32'd0) begin
            tests_failed++;
            $display("FAIL abort_async: busy=%b in_ready=%b err=%0d required 0/0/0", busy, in_ready, err_value);
        end
        in_valid = 1'b0;
        repeat (2) @(negedge CLK100MHZ);
        CPU_RESETN = 1'b1;
        repeat (5) @(negedge CLK100MHZ);
        run_pass(2048, 4, 1'b0, 1'b0, -1, tf, tl, te, ra, cs, be);
        tests_run++;
        if (err_value !== 32'd5 || LED !== 16'h0005 || cnt_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL abort_rerun: err=%0d LED=%h cnt_err=%b required 5/0005/0", err_value, LED, cnt_err);
        end
        @(negedge CLK100MHZ);
        tests_run++;
        if (ev_cnt - ev0 !== 1) begin
            tests_failed++;
            $display("FAIL abort_ev_count: err_valid pulses=%0d required 1", ev_cnt - ev0);
        end
    endtask

    task automatic test_back_to_back();
        int tf, tl, te; bit ra, cs, be;
        int ev0;
        run_pass(2048, 5, 1'b0, 1'b1, 1000, tf, tl, te, ra, cs, be);
        tests_run++;
        if (tl - tf !== 2047) begin
            tests_failed++;
            $display("FAIL b2b_throughput: span=%0d required 2047", tl - tf);
        end
        tests_run++;
        if (err_value !== 32'd1023 || cnt_err !== 1'b0 || LED !== 16'h03FF) begin
            tests_failed++;
            $display("FAIL b2b_result: err=%0d cnt_err=%b LED=%h required 1023/0/03ff", err_value, cnt_err, LED);
        end
        tests_run++;
        if (te !== tl + 4) begin tests_failed++; $display("FAIL b2b_latency: err_valid at %0d required %0d", te, tl + 4); end
        ev0 = ev_cnt;
        repeat (5) @(negedge CLK100MHZ);
        tests_run++;
        if (in_ready !== 1'b0 || busy !== 1'b0 || ev_cnt - ev0 !== 1) begin
            tests_failed++;
            $display("FAIL b2b_done_idle: in_ready=%b busy=%b extra_pulses=%0d required 0/0/1",
                     in_ready, busy, ev_cnt - ev0);
        end
        in_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_mean_basic();
        test_alternating();
        test_short_pass();
        test_extreme();
        test_reset_abort();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
